rggen_external_register_array: RTL
==================================

Name: rggen_external_register_array

Overview:
- Multi-window successor to the single external-register bridge.
- Decodes CHANNELS contiguous external windows and forwards each matching register-bus access to the owning channel through a registered valid/ready request.
- Adds a per-access response timeout that aborts a stalled access and returns a slave error.
- Sits between the register block's bus decode and up to CHANNELS external register files.

Parameters:
- ADDRESS_WIDTH, 8, register-bus address width.
- BUS_WIDTH, 32, data width; a multiple of 8.
- CHANNELS, 2, number of external windows; minimum 1.
- START_ADDRESS, 0 (ADDRESS_WIDTH bits), byte base address of window 0.
- BYTE_SIZE, 16, size of each window in bytes; a power of 2 and at least BUS_WIDTH/8. Window k spans START_ADDRESS+k*BYTE_SIZE up to START_ADDRESS+(k+1)*BYTE_SIZE-1.
- TIMEOUT_CYCLES, 0, cycles to wait for i_external_ready before aborting; 0 disables the timeout; maximum 65535.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_register_valid  in  1  register-bus request valid
- i_register_access  in  2  access type (bit0=1 write)
- i_register_address  in  ADDRESS_WIDTH  byte address
- i_register_write_data  in  BUS_WIDTH  write data
- i_register_strobe  in  BUS_WIDTH/8  byte strobes
- o_register_active  out  1  address falls in any window
- o_register_ready  out  1  response valid this cycle
- o_register_status  out  2  response status
- o_register_read_data  out  BUS_WIDTH  read data
- o_register_value  out  BUS_WIDTH  equals o_register_read_data
- o_external_valid  out  CHANNELS  one-hot request valid
- o_external_access  out  2  captured access (shared by all channels)
- o_external_address  out  ADDRESS_WIDTH  offset within the selected window
- o_external_data  out  BUS_WIDTH  captured write data
- o_external_strobe  out  BUS_WIDTH/8  captured strobes
- i_external_ready  in  CHANNELS  per-channel ready
- i_external_status  in  2*CHANNELS  per-channel status; channel k uses bits [2k+1:2k]
- i_external_data  in  BUS_WIDTH*CHANNELS  per-channel read data; channel k uses slice k
- o_timeout  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - FSM in IDLE; o_external_valid=0; o_external_access=0; o_external_address=0; timeout counter=0; captured channel index=0.
  - o_register_ready=0; o_timeout=0.
  - Write-data and strobe capture registers are not reset.
- Decode (combinational):
  - off = i_register_address - START_ADDRESS, taken modulo 2^ADDRESS_WIDTH.
  - match when i_register_address >= START_ADDRESS and off < CHANNELS*BYTE_SIZE.
  - channel index = off / BYTE_SIZE.
  - Both read and write accesses are accepted.
  - o_register_active = match, in every state.
- FSM states: IDLE, BUSY.
- IDLE:
  - On i_register_valid && match: capture channel index, access, off mod BYTE_SIZE, write data and strobes; go to BUSY.
  - o_external_valid[ch] rises on the next cycle, one cycle after acceptance.
- BUSY:
  - o_external_valid = one-hot of the captured channel; the request fields are held stable.
  - Only i_external_ready[ch] is honoured; ready from any other channel is ignored.
  - While in BUSY, i_register_valid is ignored; no new capture occurs.
- Completion: in the cycle where i_external_ready[ch]=1:
  - o_register_ready=1; status and read data come combinationally from channel ch.
  - Next cycle: IDLE, valid low, counter cleared.
- Timeout, only when TIMEOUT_CYCLES>0:
  - Counter increments once per BUSY cycle without ready.
  - In the BUSY cycle where counter==TIMEOUT_CYCLES-1 and ready is low: o_register_ready=1, o_register_status=2'b10, o_register_read_data=0, o_timeout=1. Next cycle: IDLE, valid dropped.
  - If ready coincides with the timeout cycle, the ready wins: normal response, no o_timeout.
  - Ready arriving after an abort is ignored because valid is already low.
- Outside the response cycle, o_register_read_data and o_register_status mirror channel ch's inputs; they are qualified only by o_register_ready.
- The register host holds valid until ready and drops it the cycle after. If valid is still high in the IDLE cycle after a response, a new access is accepted.
- Reset mid-access: immediate return to IDLE with valid low; no response is issued.

Test Plan:
- Defaults (START_ADDRESS=0x00, BYTE_SIZE=16, CHANNELS=2, TIMEOUT_CYCLES=0): write 0xA5A5_0001 to 0x14 with strobe 0xF -> next cycle o_external_valid=2'b10, address=0x04, data=0xA5A5_0001, strobe=0xF. Ready[1] is given 3 cycles later -> o_register_ready for 1 cycle with status=ch1 status; valid then low.
- Read 0x08 while ch0 drives data=0xDEAD_BEEF, status=0, and ready[0] arrives after 2 cycles -> o_register_ready=1, read_data=0xDEAD_BEEF, status=0; a stray ready[1] pulse during BUSY has no effect.
- Access to 0x20 (out of range) -> o_register_active=0, no o_external_valid, FSM stays IDLE; access to 0x1C -> active=1, channel 1, offset 0x0C.
- TIMEOUT_CYCLES=4, ready never asserted -> valid high for exactly 4 cycles; on the 4th: o_register_ready=1, status=2'b10, read_data=0, o_timeout=1; a late ready pulse afterwards is ignored.
- TIMEOUT_CYCLES=4, ready[0] asserted exactly in the 4th BUSY cycle -> normal response with ch0 status, o_timeout=0.
- i_rst_n pulled low mid-BUSY -> o_external_valid=0 asynchronously; no o_register_ready; after release the next access completes normally.

Source files
------------

// File: rtl/rggen_external_register_array.sv
// Multi-window external register bridge: decodes CHANNELS contiguous windows,
// forwards each access over a per-channel valid/ready request, optional timeout.
module rggen_external_register_array #(
    parameter int                         ADDRESS_WIDTH  = 8,
    parameter int                         BUS_WIDTH      = 32,
    parameter int                         CHANNELS       = 2,
    parameter logic [ADDRESS_WIDTH-1:0]   START_ADDRESS  = '0,
    parameter int                         BYTE_SIZE      = 16,
    parameter int                         TIMEOUT_CYCLES = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_register_valid,
    input  logic [1:0]                      i_register_access,
    input  logic [ADDRESS_WIDTH-1:0]        i_register_address,
    input  logic [BUS_WIDTH-1:0]            i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]          i_register_strobe,
    output logic                            o_register_active,
    output logic                            o_register_ready,
    output logic [1:0]                      o_register_status,
    output logic [BUS_WIDTH-1:0]            o_register_read_data,
    output logic [BUS_WIDTH-1:0]            o_register_value,
    output logic [CHANNELS-1:0]             o_external_valid,
    output logic [1:0]                      o_external_access,
    output logic [ADDRESS_WIDTH-1:0]        o_external_address,
    output logic [BUS_WIDTH-1:0]            o_external_data,
    output logic [BUS_WIDTH/8-1:0]          o_external_strobe,
    input  logic [CHANNELS-1:0]             i_external_ready,
    input  logic [2*CHANNELS-1:0]           i_external_status,
    input  logic [BUS_WIDTH*CHANNELS-1:0]   i_external_data,
    output logic                            o_timeout
);

    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OFF_SHIFT  = $clog2(BYTE_SIZE);
    localparam logic [63:0] SPAN = 64'(CHANNELS) * 64'(BYTE_SIZE);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'(BYTE_SIZE - 1);
    localparam logic        TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [15:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                     state_q, state_d;
    logic [CH_WIDTH-1:0]        ch_q, ch_d;
    logic [1:0]                 access_q, access_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [BUS_WIDTH-1:0]       data_q, data_d;
    logic [STRB_WIDTH-1:0]      strobe_q, strobe_d;
    logic [15:0]                count_q, count_d;

    logic [ADDRESS_WIDTH-1:0]   off;
    logic [63:0]                off_wide;
    logic                       match;
    logic [CH_WIDTH-1:0]        ch_idx;

    logic                       busy;
    logic                       sel_ready;
    logic [1:0]                 sel_status;
    logic [BUS_WIDTH-1:0]       sel_data;
    logic                       done;
    logic                       timeout_hit;
    logic                       resp;

    // Offset wraps modulo 2^ADDRESS_WIDTH; the >= check rejects wrapped values.
    always_comb begin
        off      = i_register_address - START_ADDRESS;
        off_wide = 64'(off);
        match    = (i_register_address >= START_ADDRESS) && (off_wide < SPAN);
        ch_idx   = CH_WIDTH'(off_wide >> OFF_SHIFT);
    end

    assign o_register_active = match;
    assign busy = (state_q == BUSY);

    always_comb begin
        sel_ready  = 1'b0;
        sel_status = '0;
        sel_data   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_q == CH_WIDTH'(k)) begin
                sel_ready  = i_external_ready[k];
                sel_status = i_external_status[2*k +: 2];
                sel_data   = i_external_data[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // A ready arriving in the last allowed cycle beats the abort.
    assign done        = busy && sel_ready;
    assign timeout_hit = TO_EN && busy && !sel_ready && (count_q == TO_LAST);
    assign resp        = done || timeout_hit;

    assign o_register_ready     = resp;
    assign o_timeout            = timeout_hit;
    assign o_register_status    = timeout_hit ? 2'b10 : sel_status;
    assign o_register_read_data = timeout_hit ? '0 : sel_data;
    assign o_register_value     = o_register_read_data;

    always_comb begin
        o_external_valid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            o_external_valid[k] = busy && (ch_q == CH_WIDTH'(k));
        end
    end

    assign o_external_access  = access_q;
    assign o_external_address = addr_q;
    assign o_external_data    = data_q;
    assign o_external_strobe  = strobe_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        access_d = access_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (i_register_valid && match) begin
                    state_d  = BUSY;
                    ch_d     = ch_idx;
                    access_d = i_register_access;
                    addr_d   = off & OFF_MASK;
                    data_d   = i_register_write_data;
                    strobe_d = i_register_strobe;
                    count_d  = '0;
                end
            end
            BUSY: begin
                if (resp) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (TO_EN) begin
                    count_d = count_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            access_q <= '0;
            addr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            access_q <= access_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
        end
    end

    // Payload capture carries no reset; it is qualified by o_external_valid.
    always_ff @(posedge i_clk) begin
        data_q   <= data_d;
        strobe_q <= strobe_d;
    end

endmodule
